// File: rtl/if_fetch.sv
// -----------------------------------------------------------------------------
// if_fetch -- instruction fetch unit feeding the decode stage.
//
// Owns the fetch program counter. It issues word reads to instruction memory
// over a single-outstanding req/ack handshake and buffers returned words in a
// small prefetch FIFO. It presents {pc, instruction} pairs to decode.
// Decode's PCSrc/PCWre/branch_addr inputs redirect, flush or halt fetch.
//
// Optional feature macro: IF_BYPASS_EN
//   When defined, a word returning into an empty FIFO is also presented to
//   decode combinationally in its ack cycle. If decode takes it there, the
//   word is never written into the FIFO.
//
// Parameters
//   RESET_PC       first fetch address after reset
//   FIFO_DEPTH     prefetch entries (power of two, >= 2)
//
// Ports
//   clk            sole clock, rising edge
//   rst            synchronous active-low reset
//   imem_req_o     memory read request (held until ack)
//   imem_addr_o    word address of the request, bits [1:0] = 0
//   imem_ack_i     request completed, imem_rdata_i valid this cycle
//   imem_rdata_i   returned instruction word
//   inst_valid_o   pc_o / instruction_o carry a valid instruction
//   pc_o           PC of presented instruction (0 when not valid)
//   instruction_o  presented instruction (0 when not valid)
//   id_ready_i     decode accepts the presented instruction this cycle
//   PCSrc_i        take branch_addr_i (qualified by accept)
//   PCWre_i        0 = halt fetch (qualified by accept)
//   branch_addr_i  redirect target, bits [1:0] ignored
//   halted_o       fetch stopped by halt
// -----------------------------------------------------------------------------
module if_fetch #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ack_i,
   input  logic [31:0] imem_rdata_i,
   output logic        inst_valid_o,
   output logic [31:0] pc_o,
   output logic [31:0] instruction_o,
   input  logic        id_ready_i,
   input  logic        PCSrc_i,
   input  logic        PCWre_i,
   input  logic [31:0] branch_addr_i,
   output logic        halted_o
);

   localparam int                PTR_W   = $clog2(FIFO_DEPTH);
   localparam int                CNT_W   = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_DISCARD,
      S_HALTED
   } state_t;

   state_t             r_state;
   logic               r_req;
   logic [31:0]        r_addr;
   logic [31:0]        r_fpc;
   logic               r_halted;

   logic [31:0]        r_fifo_pc   [FIFO_DEPTH];
   logic [31:0]        r_fifo_inst [FIFO_DEPTH];
   logic [PTR_W-1:0]   r_wptr;
   logic [PTR_W-1:0]   r_rptr;
   logic [CNT_W-1:0]   r_count;

   logic               w_head_valid;
   logic               w_bypass;
   logic               w_accept;
   logic               w_halt;
   logic               w_redirect;
   logic               w_bypass_take;
   logic               w_pop;
   logic               w_push;
   logic               w_ack_req;
   logic [31:0]        w_target;
   logic               w_unused;

   // Only the word-aligned part of the branch target is meaningful.
   assign w_unused = &{1'b0, branch_addr_i[1:0]};
   assign w_target = {branch_addr_i[31:2], 2'b00};

   assign w_head_valid = (r_count != '0);
   assign w_ack_req    = (r_state == S_REQ) && imem_ack_i;

`ifdef IF_BYPASS_EN
   // The returning word is shown to decode only when nothing older is queued.
   assign w_bypass = !w_head_valid && w_ack_req;
`else
   assign w_bypass = 1'b0;
`endif

   assign inst_valid_o = w_head_valid || w_bypass;

   // NOTE: every signal assigned in always_comb receives a default first, so
   // no path through the block leaves it unassigned (no inferred latch).
   always_comb begin
      pc_o          = 32'h0;
      instruction_o = 32'h0;
      if (w_head_valid) begin
         pc_o          = r_fifo_pc[r_rptr];
         instruction_o = r_fifo_inst[r_rptr];
      end else if (w_bypass) begin
         pc_o          = r_fpc;
         instruction_o = imem_rdata_i;
      end
   end

   assign w_accept      = inst_valid_o && id_ready_i;
   assign w_halt        = w_accept && !PCWre_i;
   assign w_redirect    = w_accept && PCSrc_i && PCWre_i;
   assign w_bypass_take = w_bypass && id_ready_i;
   // A bypassed word is consumed straight from the bus, so nothing is popped.
   assign w_pop         = w_accept && !w_bypass_take;
   // Returned data is dropped when the same cycle flushes or halts fetch.
   assign w_push        = w_ack_req && !w_halt && !w_redirect && !w_bypass_take;

   assign imem_req_o  = r_req;
   assign imem_addr_o = r_addr;
   assign halted_o    = r_halted;

   // NOTE: the FIFO storage is deliberately not reset. Pointers and count
   // define which entries are live, so a reset of the storage would add
   // logic without changing behaviour.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_pc[r_wptr]   <= r_fpc;
         r_fifo_inst[r_wptr] <= imem_rdata_i;
      end
   end

   // NOTE: state registers use non-blocking assignments only. Later
   // assignments in this block (flush) intentionally override earlier
   // ones (push/pop).
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state  <= S_IDLE;
         r_req    <= 1'b0;
         r_addr   <= RESET_PC;
         r_fpc    <= RESET_PC;
         r_halted <= 1'b0;
         r_wptr   <= '0;
         r_rptr   <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + 1'b1;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + 1'b1;
         end
         r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);

         if (w_halt) begin
            // Halt wins over PCSrc. Any outstanding request is abandoned.
            r_state  <= S_HALTED;
            r_req    <= 1'b0;
            r_halted <= 1'b1;
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
         end else if (w_redirect) begin
            r_fpc   <= w_target;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            if ((r_state == S_REQ || r_state == S_DISCARD) && !imem_ack_i) begin
               // The old request stays on the bus until memory completes it.
               r_state <= S_DISCARD;
            end else begin
               r_state <= S_IDLE;
               r_req   <= 1'b0;
            end
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (r_count < DEPTH_C) begin
                     r_state <= S_REQ;
                     r_req   <= 1'b1;
                     r_addr  <= r_fpc;
                  end
               end
               S_REQ: begin
                  if (imem_ack_i) begin
                     r_fpc   <= r_fpc + 32'd4;
                     r_state <= S_IDLE;
                     r_req   <= 1'b0;
                  end
               end
               S_DISCARD: begin
                  if (imem_ack_i) begin
                     r_state <= S_IDLE;
                     r_req   <= 1'b0;
                  end
               end
               S_HALTED: begin
                  r_req <= 1'b0;
               end
               default: begin
                  r_state <= S_IDLE;
                  r_req   <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_if_fetch.sv
// -----------------------------------------------------------------------------
// tb_if_fetch -- directed self-checking bench for if_fetch.
// The memory model returns (address ^ mem_mask) after mem_lat wait cycles.
// Inputs are driven 2 time units after the rising edge. Outputs are sampled
// on the falling edge.
// -----------------------------------------------------------------------------
module tb_if_fetch;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_ack_i;
   logic [31:0] imem_rdata_i;
   logic        inst_valid_o;
   logic [31:0] pc_o;
   logic [31:0] instruction_o;
   logic        id_ready_i;
   logic        PCSrc_i;
   logic        PCWre_i;
   logic [31:0] branch_addr_i;
   logic        halted_o;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          n_ack   = 0;
   int          n_acc   = 0;
   int          ack_base = 0;
   int          mem_lat = 0;
   int          mem_cnt = 0;
   logic [31:0] mem_mask = 32'h0;
   logic        force_ack = 1'b0;
   logic [31:0] acc_pc   [$];
   logic [31:0] acc_inst [$];

   if_fetch #(
      .RESET_PC   (32'h0000_0000),
      .FIFO_DEPTH (2)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_ack_i    (imem_ack_i),
      .imem_rdata_i  (imem_rdata_i),
      .inst_valid_o  (inst_valid_o),
      .pc_o          (pc_o),
      .instruction_o (instruction_o),
      .id_ready_i    (id_ready_i),
      .PCSrc_i       (PCSrc_i),
      .PCWre_i       (PCWre_i),
      .branch_addr_i (branch_addr_i),
      .halted_o      (halted_o)
   );

   always #5 clk = ~clk;

   // Instruction memory model.
   initial begin
      imem_ack_i   = 1'b0;
      imem_rdata_i = 32'h0;
      forever begin
         @(posedge clk);
         #1;
         if (force_ack) begin
            imem_ack_i   = 1'b1;
            imem_rdata_i = 32'hDEAD_BEEF;
         end else if (imem_req_o) begin
            if (mem_cnt >= mem_lat) begin
               imem_ack_i   = 1'b1;
               imem_rdata_i = imem_addr_o ^ mem_mask;
               n_ack++;
               mem_cnt = 0;
            end else begin
               imem_ack_i = 1'b0;
               mem_cnt++;
            end
         end else begin
            imem_ack_i = 1'b0;
            mem_cnt    = 0;
         end
      end
   end

   // Record every instruction decode accepts.
   always @(negedge clk) begin
      if (inst_valid_o && id_ready_i) begin
         acc_pc.push_back(pc_o);
         acc_inst.push_back(instruction_o);
         n_acc++;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst           = 1'b0;
      id_ready_i    = 1'b0;
      PCSrc_i       = 1'b0;
      PCWre_i       = 1'b1;
      branch_addr_i = 32'h0;
      mem_lat       = 0;
      force_ack     = 1'b0;
      tick();
      tick();
      ack_base = n_ack;
   endtask

   task automatic wait_acks(input int n, input string tag);
      int k = 0;
      while (n_ack < ack_base + n && k < 100) begin
         tick();
         k++;
      end
      if (n_ack < ack_base + n) check(tag, n_ack - ack_base, n);
   endtask

   task automatic wait_acc(input int n, input string tag);
      int k = 0;
      while (acc_pc.size() < n && k < 200) begin
         tick();
         k++;
      end
      if (acc_pc.size() < n) check(tag, acc_pc.size(), n);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          base;
      int          bad;
      int          k;
      logic [31:0] lastpc;

      // ---------------- reset values ----------------
      do_reset();
      sample();
      check("rst_req",   {31'h0, imem_req_o},   32'h0);
      check("rst_addr",  imem_addr_o,           32'h0);
      check("rst_valid", {31'h0, inst_valid_o}, 32'h0);
      check("rst_pc",    pc_o,                  32'h0);
      check("rst_inst",  instruction_o,         32'h0);
      check("rst_halt",  {31'h0, halted_o},     32'h0);

      // ---------------- sequential fetch, zero-wait ----------------
      rst        = 1'b1;
      id_ready_i = 1'b1;
      base       = acc_pc.size();
      tick();
      sample();
      check("first_req",  {31'h0, imem_req_o}, 32'h1);
      check("first_addr", imem_addr_o,         32'h0);
      wait_acc(base + 3, "seq_timeout");
      for (int i = 0; i < 3; i++) begin
         check("seq_pc",   acc_pc[base+i],   32'(4 * i));
         check("seq_inst", acc_inst[base+i], 32'(4 * i));
      end

      // ---------------- decode stall fills the FIFO ----------------
      tick();
      id_ready_i = 1'b0;
      lastpc     = acc_pc[acc_pc.size()-1];
      repeat (10) tick();
      sample();
      check("full_req",     {31'h0, imem_req_o}, 32'h0);
      check("full_count",   n_ack - n_acc,       32'd2);
      check("full_head_pc", pc_o,                lastpc + 32'd4);
      check("full_head_in", instruction_o,       lastpc + 32'd4);
      base       = acc_pc.size();
      id_ready_i = 1'b1;
      wait_acc(base + 4, "drain_timeout");
      for (int i = 0; i < 4; i++) begin
         check("drain_pc",   acc_pc[base+i],   lastpc + 32'(4 * (i + 1)));
         check("drain_inst", acc_inst[base+i], lastpc + 32'(4 * (i + 1)));
      end

      // ---------------- redirect with an outstanding request ----------------
      do_reset();
      rst = 1'b1;
      wait_acks(2, "redir_fill_timeout");
      tick();                      // FIFO holds 0x0, 0x4
      id_ready_i = 1'b1;           // accept 0x0
      tick();
      id_ready_i = 1'b0;
      tick();                      // 0x8 requested and acked
      tick();                      // FIFO holds 0x4, 0x8
      mem_lat    = 3;
      id_ready_i = 1'b1;           // accept 0x4
      tick();
      id_ready_i = 1'b0;
      tick();                      // request to 0xC now outstanding
      check("redir_pre_req",  {31'h0, imem_req_o}, 32'h1);
      check("redir_pre_addr", imem_addr_o,         32'hC);
      check("redir_pre_head", pc_o,                32'h8);
      id_ready_i    = 1'b1;        // accept 0x8 with branch to 0x103
      PCSrc_i       = 1'b1;
      branch_addr_i = 32'h0000_0103;
      tick();
      id_ready_i = 1'b0;
      PCSrc_i    = 1'b0;
      base       = acc_pc.size();
      sample();
      check("disc_req",   {31'h0, imem_req_o},   32'h1);
      check("disc_addr",  imem_addr_o,           32'hC);
      check("disc_valid", {31'h0, inst_valid_o}, 32'h0);
      k = 0;
      tick();
      while (!(imem_req_o && imem_addr_o != 32'hC) && k < 20) begin
         tick();
         k++;
      end
      check("redir_addr", imem_addr_o, 32'h100);
      mem_lat    = 0;
      id_ready_i = 1'b1;
      wait_acc(base + 2, "redir_timeout");
      check("redir_pc0",   acc_pc[base],     32'h100);
      check("redir_inst0", acc_inst[base],   32'h100);
      check("redir_pc1",   acc_pc[base+1],   32'h104);

      // ---------------- halt (wins over PCSrc), late ack ignored ----------------
      do_reset();
      rst = 1'b1;
      wait_acks(2, "halt_fill_timeout");
      tick();
      mem_lat    = 5;
      id_ready_i = 1'b1;           // accept 0x0
      tick();
      id_ready_i = 1'b0;
      tick();                      // request to 0x8 outstanding
      check("halt_pre_req", {31'h0, imem_req_o}, 32'h1);
      id_ready_i    = 1'b1;
      PCWre_i       = 1'b0;
      PCSrc_i       = 1'b1;
      branch_addr_i = 32'h40;
      tick();
      PCWre_i = 1'b1;
      PCSrc_i = 1'b0;
      sample();
      check("halt_flag",  {31'h0, halted_o},     32'h1);
      check("halt_req",   {31'h0, imem_req_o},   32'h0);
      check("halt_valid", {31'h0, inst_valid_o}, 32'h0);
      force_ack = 1'b1;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         sample();
         force_ack = 1'b0;
         if (inst_valid_o || imem_req_o || !halted_o) bad++;
      end
      check("halt_stays", bad,           32'd0);
      check("halt_pc",    pc_o,          32'h0);
      check("halt_inst",  instruction_o, 32'h0);

      // ---------------- reset while memory stalls ----------------
      do_reset();
      rst = 1'b1;
      wait_acks(1, "mid_fill_timeout");
      mem_lat = 100;
      repeat (3) tick();
      sample();
      check("mid_req",   {31'h0, imem_req_o},   32'h1);
      check("mid_addr",  imem_addr_o,           32'h4);
      check("mid_valid", {31'h0, inst_valid_o}, 32'h1);
      rst = 1'b0;
      tick();
      sample();
      check("mid_rst_req",   {31'h0, imem_req_o},   32'h0);
      check("mid_rst_valid", {31'h0, inst_valid_o}, 32'h0);
      check("mid_rst_addr",  imem_addr_o,           32'h0);
      rst     = 1'b1;
      mem_lat = 0;
      tick();
      sample();
      check("mid_rel_req",  {31'h0, imem_req_o}, 32'h1);
      check("mid_rel_addr", imem_addr_o,         32'h0);

      // ---------------- fetch-to-decode latency ----------------
      mem_mask = 32'h2400_0001;
      do_reset();
      id_ready_i = 1'b1;
      rst        = 1'b1;
      tick();                      // request to 0x0; ack arrives this cycle
      sample();
`ifdef IF_BYPASS_EN
      check("byp_valid", {31'h0, inst_valid_o}, 32'h1);
      check("byp_inst",  instruction_o,         32'h2400_0001);
      check("byp_pc",    pc_o,                  32'h0);
      tick();
      sample();
      check("byp_nopush", {31'h0, inst_valid_o}, 32'h0);
`else
      check("lat_ack_valid", {31'h0, inst_valid_o}, 32'h0);
      tick();
      sample();
      check("lat_valid", {31'h0, inst_valid_o}, 32'h1);
      check("lat_inst",  instruction_o,         32'h2400_0001);
      check("lat_pc",    pc_o,                  32'h0);
`endif
      mem_mask = 32'h0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
